chip8_draw_ctrl: RTL

Sequencer for the CHIP-8 DXYN sprite draw. It fetches up to 15 sprite bytes from main memory and issues one row at a time to the display XOR unit. It accumulates that unit's per-row collision result into a VF flag for the CPU. It sits between the instruction decoder/CPU, the memory port and the display unit.

---
 rtl/chip8_pkg.sv | 7 +
 rtl/chip8_draw_ctrl_if.sv | 29 ++
 rtl/chip8_draw_ctrl.sv | 71 +++++++
 3 files changed

// File: rtl/chip8_pkg.sv
// chip8_pkg: display geometry, memory address width and draw FSM states shared by the draw sequencer
package chip8_pkg;
  localparam int DISP_W = 64;
  localparam int DISP_H = 32;
  localparam int ADDR_W = 12;
  typedef enum logic [2:0] {IDLE, FETCH, DRAW, WAIT, DONE} draw_state_e;
endpackage

// File: rtl/chip8_draw_ctrl_if.sv
// chip8_draw_ctrl_if: CPU request, memory read port and display unit signals of the draw sequencer
interface chip8_draw_ctrl_if #(parameter int ADDR_W = chip8_pkg::ADDR_W);
  logic              start;
  logic [5:0]        x;
  logic [4:0]        y;
  logic [3:0]        n;
  logic [ADDR_W-1:0] i_addr;
  logic              busy;
  logic              done;
  logic              vf;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic              draw;
  logic [5:0]        draw_x;
  logic [4:0]        draw_y;
  logic [3:0]        row_index;
  logic [7:0]        sprite_data;
  logic              disp_collision;
  modport master (
    input  start, x, y, n, i_addr, mem_ack, mem_rdata, disp_collision,
    output busy, done, vf, mem_req, mem_addr, draw, draw_x, draw_y, row_index, sprite_data
  );
  modport slave (
    output start, x, y, n, i_addr, mem_ack, mem_rdata, disp_collision,
    input  busy, done, vf, mem_req, mem_addr, draw, draw_x, draw_y, row_index, sprite_data
  );
endinterface

// File: rtl/chip8_draw_ctrl.sv
// chip8_draw_ctrl: DXYN sprite fetch/draw sequencer that accumulates display collisions into VF.
// Define CHIP8_DRAW_CLIP_EN to stop at the bottom display edge instead of leaving wrap to the display unit.
module chip8_draw_ctrl #(parameter int ADDR_W = chip8_pkg::ADDR_W) (
  input logic clk,
  input logic rst_n,
  chip8_draw_ctrl_if.master bus
);
  import chip8_pkg::*;
  draw_state_e       state_q, state_d;
  logic [5:0]        x_q;
  logic [4:0]        y_q;
  logic [3:0]        n_q, row_q;
  logic [ADDR_W-1:0] i_q;
  logic [7:0]        data_q;
  logic              vf_q;
  logic              last_row;
  always_comb begin
    last_row = (row_q == n_q - 4'd1);
`ifdef CHIP8_DRAW_CLIP_EN
    last_row = last_row || ({2'b0, y_q} + {3'b0, row_q} + 7'd1 >= 7'(DISP_H));
`endif
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.start ? (bus.n == 4'd0 ? DONE : FETCH) : IDLE;
      FETCH:   state_d = bus.mem_ack ? DRAW : FETCH;
      DRAW:    state_d = WAIT;
      WAIT:    state_d = last_row ? DONE : FETCH;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      n_q     <= '0;
      row_q   <= '0;
      i_q     <= '0;
      data_q  <= '0;
      vf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.start) begin
        x_q   <= bus.x;
        y_q   <= bus.y;
        n_q   <= bus.n;
        i_q   <= bus.i_addr;
        row_q <= '0;
        vf_q  <= 1'b0;
      end
      if (state_q == FETCH && bus.mem_ack) data_q <= bus.mem_rdata;
      // collision arrives registered, so WAIT is the only cycle it belongs to the row just drawn
      if (state_q == WAIT) begin
        vf_q <= vf_q | bus.disp_collision;
        if (!last_row) row_q <= row_q + 4'd1;
      end
    end
  end
  assign bus.busy        = state_q inside {FETCH, DRAW, WAIT};
  assign bus.done        = state_q == DONE;
  assign bus.vf          = vf_q;
  assign bus.mem_req     = state_q == FETCH;
  assign bus.mem_addr    = i_q + ADDR_W'(row_q);
  assign bus.draw        = state_q == DRAW;
  assign bus.draw_x      = x_q;
  assign bus.draw_y      = y_q;
  assign bus.row_index   = row_q;
  assign bus.sprite_data = data_q;
endmodule
